// File: rtl/regfile_host_port_if.sv
// Host command/response channel for regfile_host_port.
//   master : host side, issues commands and accepts responses
//   slave  : regfile_host_port side
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata (command),
//          rsp_valid/rsp_ready/rsp_data/rsp_err (response).
interface regfile_host_port_if #(
    parameter int DW = 24,
    parameter int AW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/regfile_host_port.sv
// regfile_host_port: host-side initiator for the 16x24 register file.
// Accepts one host command at a time, performs the regfile read (and optional
// write) in a single EXEC cycle, then presents one response.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   host (slave)    command/response channel (see regfile_host_port_if)
//   txn_count       completed responses, saturating
//   rf_we/rf_dst    regfile write enable / address
//   rf_src0/rf_src1 regfile read addresses (both the latched command address)
//   rf_data         regfile write data
//   rf_outa/rf_outb regfile read data (port B unused)
//
// Build option: define REGFILE_HOST_RMW_EN to build the ADD/XOR datapath.
// Without it ADD/XOR are rejected with rsp_err and no write.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC  | regfile addressed, pre-write value captured, write (if any) commits
// RESP  | rsp_valid high, response held until rsp_ready
module regfile_host_port #(
    parameter int                 DW      = 24,
    parameter int                 AW      = 4,
    parameter logic [2**AW-1:0]   WP_MASK = 16'h0008,
    parameter int                 CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_host_port_if.slave    host,
    output logic [CNT_W-1:0]      txn_count,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_dst,
    output logic [AW-1:0]         rf_src0,
    output logic [AW-1:0]         rf_src1,
    output logic [DW-1:0]         rf_data,
    input  logic [DW-1:0]         rf_outa,
    input  logic [DW-1:0]         rf_outb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_XOR   = 2'b11;

    state_t        state, state_nxt;
    logic          accept;
    logic          rsp_done;

    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;

    logic [DW-1:0] wr_data;
    logic          op_err;
    logic          wr_req;
    logic          reject;

    logic          unused_rf_outb;
    assign unused_rf_outb = ^rf_outb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (host.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (host.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operation decode on the latched command; rf_outa is the live
    // (pre-write) value of the addressed register during EXEC.
    always_comb begin
        wr_data = '0;
        op_err  = 1'b0;
        case (op_q)
            OP_READ:  wr_data = '0;
            OP_WRITE: wr_data = wdata_q;
`ifdef REGFILE_HOST_RMW_EN
            OP_ADD:   wr_data = rf_outa + wdata_q;
            OP_XOR:   wr_data = rf_outa ^ wdata_q;
`else
            OP_ADD:   op_err  = 1'b1;
            OP_XOR:   op_err  = 1'b1;
`endif
            default:  wr_data = '0;
        endcase
    end

    assign wr_req = (op_q != OP_READ);
    assign reject = wr_req && (WP_MASK[addr_q] || op_err);

    // Decoded from registered state so a falling rst_n kills the write at once.
    assign rf_we   = (state == EXEC) && wr_req && !reject;
    assign rf_data = rf_we ? wr_data : '0;
    assign rf_dst  = addr_q;
    assign rf_src0 = addr_q;
    assign rf_src1 = addr_q;

    assign host.cmd_ready = (state == IDLE);
    assign host.rsp_valid = (state == RESP);
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            txn_count  <= '0;
        end else begin
            if (accept) begin
                op_q    <= host.cmd_op;
                addr_q  <= host.cmd_addr;
                wdata_q <= host.cmd_wdata;
            end
            if (state == EXEC) begin
                rsp_data_q <= rf_outa;
                rsp_err_q  <= reject;
            end
            if (rsp_done && (txn_count != {CNT_W{1'b1}})) begin
                txn_count <= txn_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_host_port.sv
module tb_regfile_host_port;

    localparam int DW = 24;
    localparam int AW = 4;
    localparam int CW = 2;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [23:0] wdata;
        logic [23:0] exp_data;
        logic        exp_err;
        int          exp_we;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          rf_rst_n;
    logic [CW-1:0] txn_count;
    logic          rf_we;
    logic [AW-1:0] rf_dst, rf_src0, rf_src1;
    logic [DW-1:0] rf_data, rf_outa, rf_outb;

    regfile_host_port_if #(.DW(DW), .AW(AW)) host ();

    regfile_host_port #(.DW(DW), .AW(AW), .WP_MASK(16'h0008), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host.slave),
        .txn_count (txn_count),
        .rf_we     (rf_we),
        .rf_dst    (rf_dst),
        .rf_src0   (rf_src0),
        .rf_src1   (rf_src1),
        .rf_data   (rf_data),
        .rf_outa   (rf_outa),
        .rf_outb   (rf_outb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] rf_init(input int i);
        logic [7:0] b;
        b = i[7:0];
        case (i)
            0:       return 24'h901100;
            3:       return 24'h000000;
            5:       return 24'h000000;
            7:       return 24'hE0A7A7;
            9:       return 24'h200000;
            12:      return 24'h000001;
            default: return {b, b, b};
        endcase
    endfunction

    // Behavioural regfile: combinational reads, posedge writes, own sync reset.
    logic [23:0] rf_mem [16];
    always @(posedge clk) begin
        if (!rf_rst_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init(i);
        end else if (rf_we) begin
            rf_mem[rf_dst] <= rf_data;
        end
    end
    assign rf_outa = rf_mem[rf_src0];
    assign rf_outb = rf_mem[rf_src1];

    int we_cnt = 0;
    always @(posedge clk) if (rf_we === 1'b1) we_cnt <= we_cnt + 1;

    int   nvec  = 0;
    int   nfail = 0;
    int   exp_cnt = 0;
    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (host.cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        chk({nm, "_ready_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input string nm, output int lat);
        bit ok;
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (host.rsp_valid === 1'b1) begin ok = 1; break; end
        end
        chk({nm, "_rsp_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 3) exp_cnt++;
    endtask

    task automatic run_cmd(input vec_t v, input string nm);
        int lat, base;
        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_op    = v.op;
        host.cmd_addr  = v.addr;
        host.cmd_wdata = v.wdata;
        host.rsp_ready = 1'b1;
        wait_ready(nm);
        base = we_cnt;
        @(posedge clk);
        #1 host.cmd_valid = 1'b0;
        wait_rsp(nm, lat);
        // Accept edge -> EXEC -> RESP: valid first seen at the 2nd negedge after accept.
        chk({nm, "_lat"}, 32'(lat), 32'd2);
        chk({nm, "_data"}, 32'(host.rsp_data), 32'(v.exp_data));
        chk({nm, "_err"}, 32'(host.rsp_err), 32'(v.exp_err));
        @(posedge clk);
        #1;
        bump_cnt();
        chk({nm, "_cnt"}, 32'(txn_count), 32'(exp_cnt));
        chk({nm, "_we_pulses"}, 32'(we_cnt - base), 32'(v.exp_we));
        chk({nm, "_valid_drop"}, 32'(host.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat, base;
        vec_t v;

        vecs[0]  = '{2'd0, 4'd0,  24'h000000, 24'h901100, 1'b0, 0};
        vecs[1]  = '{2'd1, 4'd5,  24'hABCDEF, 24'h000000, 1'b0, 1};
        vecs[2]  = '{2'd0, 4'd5,  24'h000000, 24'hABCDEF, 1'b0, 0};
        vecs[3]  = '{2'd1, 4'd3,  24'h000001, 24'h000000, 1'b1, 0};
        vecs[4]  = '{2'd0, 4'd3,  24'h000000, 24'h000000, 1'b0, 0};
`ifdef REGFILE_HOST_RMW_EN
        vecs[5]  = '{2'd2, 4'd12, 24'hFFFFFF, 24'h000001, 1'b0, 1};
        vecs[6]  = '{2'd0, 4'd12, 24'h000000, 24'h000000, 1'b0, 0};
        vecs[7]  = '{2'd3, 4'd7,  24'hFFFFFF, 24'hE0A7A7, 1'b0, 1};
        vecs[8]  = '{2'd0, 4'd7,  24'h000000, 24'h1F5858, 1'b0, 0};
        vecs[9]  = '{2'd2, 4'd9,  24'h000001, 24'h200000, 1'b0, 1};
        vecs[10] = '{2'd0, 4'd9,  24'h000000, 24'h200001, 1'b0, 0};
`else
        vecs[5]  = '{2'd2, 4'd9,  24'h123456, 24'h200000, 1'b1, 0};
        vecs[6]  = '{2'd0, 4'd9,  24'h000000, 24'h200000, 1'b0, 0};
        vecs[7]  = '{2'd3, 4'd7,  24'hFFFFFF, 24'hE0A7A7, 1'b1, 0};
        vecs[8]  = '{2'd0, 4'd7,  24'h000000, 24'hE0A7A7, 1'b0, 0};
        vecs[9]  = '{2'd2, 4'd12, 24'hFFFFFF, 24'h000001, 1'b1, 0};
        vecs[10] = '{2'd0, 4'd12, 24'h000000, 24'h000001, 1'b0, 0};
`endif
        vecs[11] = '{2'd3, 4'd3,  24'h00FF00, 24'h000000, 1'b1, 0};
        vecs[12] = '{2'd1, 4'd0,  24'h000042, 24'h901100, 1'b0, 1};
        vecs[13] = '{2'd0, 4'd0,  24'h000000, 24'h000042, 1'b0, 0};
        vecs[14] = '{2'd1, 4'd15, 24'h5A5A5A, 24'h0F0F0F, 1'b0, 1};
        vecs[15] = '{2'd0, 4'd15, 24'h000000, 24'h5A5A5A, 1'b0, 0};

        host.cmd_valid = 1'b0;
        host.cmd_op    = 2'd0;
        host.cmd_addr  = '0;
        host.cmd_wdata = '0;
        host.rsp_ready = 1'b0;
        rst_n    = 1'b0;
        rf_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rf_rst_n = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);

        chk("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(host.rsp_data),  32'd0);
        chk("rst_rsp_err",   32'(host.rsp_err),   32'd0);
        chk("rst_txn_count", 32'(txn_count),      32'd0);
        chk("rst_rf_we",     32'(rf_we),          32'd0);
        chk("rst_rf_addr",   32'({rf_dst, rf_src0, rf_src1}), 32'd0);
        chk("rst_rf_data",   32'(rf_data),        32'd0);

        for (int i = 0; i < 16; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Response back-pressure with a second command already waiting.
        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'd0;
        host.cmd_addr  = 4'd5;
        host.cmd_wdata = '0;
        host.rsp_ready = 1'b0;
        wait_ready("hold");
        base = we_cnt;
        @(posedge clk);
        #1;
        host.cmd_op    = 2'd1;
        host.cmd_addr  = 4'd8;
        host.cmd_wdata = 24'h000077;
        wait_rsp("hold", lat);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(host.rsp_valid), 32'd1);
            chk("hold_data",  32'(host.rsp_data),  32'hABCDEF);
            chk("hold_ready", 32'(host.cmd_ready), 32'd0);
            @(negedge clk);
        end
        host.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bump_cnt();
        chk("hold_cnt", 32'(txn_count), 32'(exp_cnt));
        chk("hold_idle_ready", 32'(host.cmd_ready), 32'd1);
        @(posedge clk);
        #1 host.cmd_valid = 1'b0;
        wait_rsp("queued", lat);
        chk("queued_data", 32'(host.rsp_data), 32'h080808);
        chk("queued_err",  32'(host.rsp_err),  32'd0);
        @(posedge clk);
        #1;
        bump_cnt();
        chk("queued_we_pulses", 32'(we_cnt - base), 32'd1);
        @(negedge clk);
        chk("queued_no_dup", 32'(host.rsp_valid), 32'd0);
        chk("queued_ready",  32'(host.cmd_ready), 32'd1);
        v = '{2'd0, 4'd8, 24'h000000, 24'h000077, 1'b0, 0};
        run_cmd(v, "rd8");

        // Reset during EXEC of a write: the write must be suppressed.
        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'd1;
        host.cmd_addr  = 4'd6;
        host.cmd_wdata = 24'h123456;
        host.rsp_ready = 1'b1;
        wait_ready("rstx");
        base = we_cnt;
        @(posedge clk);
        #1 host.cmd_valid = 1'b0;
        chk("rstx_we_exec", 32'(rf_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstx_we_drop",  32'(rf_we),          32'd0);
        chk("rstx_rsp_valid", 32'(host.rsp_valid), 32'd0);
        chk("rstx_cnt",      32'(txn_count),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("rstx_we_pulses", 32'(we_cnt - base), 32'd0);
        v = '{2'd0, 4'd6, 24'h000000, 24'h060606, 1'b0, 0};
        run_cmd(v, "rd6_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
